led_pwm_bank: RTL

//   Parametrised LED output bank for the icestick board tops; supersedes wiring CPU out_led bits straight to pins.
//   NUM_LEDS channels, each with a mode (off/on/pwm/blink) and a PWM duty value, written by the myrisc16 core

---
 rtl/led_pwm_bank_pkg.sv | 14 +
 rtl/led_pwm_bank_if.sv | 26 ++
 rtl/led_pwm_bank_channel.sv | 56 +++++
 rtl/led_pwm_bank.sv | 126 ++++++++++++
 4 files changed

// File: rtl/led_pwm_bank_pkg.sv
// Shared constants for the LED PWM bank: channel modes, CTRL bit, config field layout.
package led_pwm_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_PWM   = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_MODE_W   = 2;
  localparam int CFG_DUTY_LSB = 2;

endpackage

// File: rtl/led_pwm_bank_if.sv
// Register port between the CPU I/O bus and the LED bank.
//
// Handshake: there is no ready. A write strobe (in_wr_en) is always accepted on
// the edge it is sampled. A read strobe (in_rd_en) sampled at edge N produces
// out_rd_data with out_rd_valid high for exactly the cycle following edge N;
// out_rd_data keeps the last read value while out_rd_valid is low.
interface led_pwm_bank_if #(
  parameter int AW = 3
);
  logic          in_wr_en;
  logic [AW-1:0] in_addr;
  logic [15:0]   in_wr_data;
  logic          in_rd_en;
  logic [15:0]   out_rd_data;
  logic          out_rd_valid;

  modport master (
    output in_wr_en, in_addr, in_wr_data, in_rd_en,
    input  out_rd_data, out_rd_valid
  );

  modport slave (
    input  in_wr_en, in_addr, in_wr_data, in_rd_en,
    output out_rd_data, out_rd_valid
  );
endinterface

// File: rtl/led_pwm_bank_channel.sv
// One LED channel: config register, period-aligned duty shadow and next LED bit.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [PWM_BITS+1:0] i_wr_data,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_wrap,
  input  logic                i_blink_phase,
  output logic                o_led_next,
  output logic [15:0]         o_cfg
);

  logic [1:0]          r_mode;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_duty_shadow;
  logic                w_pwm_on;

  // Config write; the shadow takes the pre-edge duty only at a period boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode        <= MODE_OFF;
      r_duty        <= '0;
      r_duty_shadow <= '0;
    end else begin
      if (i_wr_en) begin
        r_mode <= i_wr_data[CFG_MODE_LSB +: CFG_MODE_W];
        r_duty <= i_wr_data[CFG_DUTY_LSB +: PWM_BITS];
      end
      if (i_wrap) begin
        r_duty_shadow <= r_duty;
      end
    end
  end

  // Next LED bit from mode, shadowed duty and blink phase; also readback word.
  always_comb begin
    o_led_next = 1'b0;
    o_cfg      = '0;
    w_pwm_on   = (i_pwm_cnt < r_duty_shadow);
    case (r_mode)
      MODE_OFF:   o_led_next = 1'b0;
      MODE_ON:    o_led_next = 1'b1;
      MODE_PWM:   o_led_next = w_pwm_on;
      MODE_BLINK: o_led_next = i_blink_phase & w_pwm_on;
      default:    o_led_next = 1'b0;
    endcase
    o_cfg[CFG_MODE_LSB +: CFG_MODE_W] = r_mode;
    o_cfg[CFG_DUTY_LSB +: PWM_BITS]   = r_duty;
  end

endmodule

// File: rtl/led_pwm_bank.sv
// LED output bank: shared PWM/blink timebase, CTRL enable, register readback
// and the registered LED outputs for NUM_LEDS channels.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int  NUM_LEDS       = 5,
  parameter int  PWM_BITS       = 8,
  parameter int  PWM_DIV        = 4,
  parameter int  BLINK_DIV_BITS = 22,
  localparam int AW             = $clog2(NUM_LEDS + 1)
) (
  input  logic                in_clock,
  input  logic                in_reset,
  led_pwm_bank_if.slave       bus,
  output logic [NUM_LEDS-1:0] out_led,
  output logic                out_pwm_wrap
);

  // Prescaler needs at least one bit even when PWM_DIV is 1.
  localparam int              PS_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_DIV - 1);

  logic [PS_W-1:0]           r_presc;
  logic [PWM_BITS-1:0]       r_pwm_cnt;
  logic [BLINK_DIV_BITS-1:0] r_blink_cnt;
  logic                      r_enable;
  logic [NUM_LEDS-1:0]       r_led;
  logic                      r_wrap;
  logic [15:0]               r_rd_data;
  logic                      r_rd_valid;

  logic                w_tick;
  logic                w_wrap;
  logic                w_blink_phase;
  logic                w_ctrl_wr;
  logic [NUM_LEDS-1:0] w_ch_wr;
  logic [NUM_LEDS-1:0] w_led_next;
  logic [15:0]         w_cfg [NUM_LEDS];
  logic [15:0]         w_rd_mux;
  logic                w_unused_wr_data;

  assign w_tick           = (r_presc == PS_LAST);
  assign w_wrap           = w_tick && (r_pwm_cnt == {PWM_BITS{1'b1}});
  assign w_blink_phase    = r_blink_cnt[BLINK_DIV_BITS-1];
  assign w_ctrl_wr        = bus.in_wr_en && (bus.in_addr == AW'(NUM_LEDS));
  // Config bits above the duty field are write-ignored.
  assign w_unused_wr_data = ^bus.in_wr_data[15:PWM_BITS+2];

  // Free-running timebase: prescaler, PWM counter, blink counter, wrap strobe.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_presc     <= '0;
      r_pwm_cnt   <= '0;
      r_blink_cnt <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
      r_blink_cnt <= r_blink_cnt + 1'b1;
      r_wrap      <= w_wrap;
    end
  end

  // Global enable register.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_enable <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_enable <= bus.in_wr_data[CTRL_EN_BIT];
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    assign w_ch_wr[g] = bus.in_wr_en && (bus.in_addr == AW'(g));

    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .i_clk        (in_clock),
      .i_rst        (in_reset),
      .i_wr_en      (w_ch_wr[g]),
      .i_wr_data    (bus.in_wr_data[PWM_BITS+1:0]),
      .i_pwm_cnt    (r_pwm_cnt),
      .i_wrap       (w_wrap),
      .i_blink_phase(w_blink_phase),
      .o_led_next   (w_led_next[g]),
      .o_cfg        (w_cfg[g])
    );
  end

  // Read mux: channel configs, then CTRL, anything above reads as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (bus.in_addr == AW'(i)) begin
        w_rd_mux = w_cfg[i];
      end
    end
    if (bus.in_addr == AW'(NUM_LEDS)) begin
      w_rd_mux = 16'(r_enable);
    end
  end

  // Registered read response and LED drive gated by the global enable.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_led      <= '0;
    end else begin
      r_rd_valid <= bus.in_rd_en;
      if (bus.in_rd_en) begin
        r_rd_data <= w_rd_mux;
      end
      r_led <= r_enable ? w_led_next : '0;
    end
  end

  assign out_led          = r_led;
  assign out_pwm_wrap     = r_wrap;
  assign bus.out_rd_data  = r_rd_data;
  assign bus.out_rd_valid = r_rd_valid;

endmodule
